// File: rtl/payload_realigner.sv
// rtl/payload_realigner.sv - header strip and payload realign stage of the packet dissector
// Captures the first HDR_BYTES bytes as a flat header and re-packs the rest so payload byte 0 sits in lane 0.
module payload_realigner #(
   parameter int DATA_BYTES = 8,
   parameter int HDR_BYTES  = 14
) (
   input  logic                    iClk,
   input  logic                    iReset,
   input  logic                    iValid,
   output logic                    oReady,
   input  logic [DATA_BYTES*8-1:0] iPacket,
   input  logic                    iSop,
   input  logic                    iEop,
   input  logic [DATA_BYTES-1:0]   iByte_enable,
   output logic [DATA_BYTES*8-1:0] oPayload,
   output logic                    oPayload_valid,
   input  logic                    iPayload_ready,
   output logic                    oSop,
   output logic                    oEop,
   output logic [DATA_BYTES-1:0]   oByte_enable,
   output logic [HDR_BYTES*8-1:0]  oHeader,
   output logic                    oHeader_valid,
   output logic                    oRunt
);
   localparam int W    = DATA_BYTES * 8;
   localparam int OFF  = HDR_BYTES % DATA_BYTES;
   localparam int OFFE = (OFF == 0) ? DATA_BYTES : OFF;   // header bytes in the last header word
   localparam int R    = DATA_BYTES - OFFE;               // residual bytes carried between words
   localparam int HW   = (HDR_BYTES + DATA_BYTES - 1) / DATA_BYTES;
   localparam int CW   = $clog2(DATA_BYTES) + 1;
   localparam int WCW  = $clog2(HW + 1);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, FLUSH} state_t;

   state_t             state, state_nxt;
   logic [WCW-1:0]     wcnt, wcnt_nxt, idx;
   logic [HW*W-1:0]    shadow, hdr_full;
   logic [W-1:0]       resid;
   logic               first_pend, first_nxt;
   logic [CW-1:0]      flush_n, flush_nxt, v;
   logic [CW:0]        total;
   logic               accept, capture, shadow_wr, resid_ld, commit, runt_nxt;
   logic               load_out, emit_sop, emit_eop;
   logic [W-1:0]       emit_data;
   logic [DATA_BYTES-1:0] emit_be;

   function automatic logic [CW-1:0] count_bytes(input logic [DATA_BYTES-1:0] be);
      logic [CW-1:0] n;
      n = '0;
      for (int k = 0; k < DATA_BYTES; k++) n = n + CW'(be[k]);
      return n;
   endfunction

   function automatic logic [DATA_BYTES-1:0] top_mask(input logic [CW-1:0] n);
      logic [DATA_BYTES-1:0] m;
      m = '0;
      for (int k = 0; k < DATA_BYTES; k++)
         if (CW'(k) < n) m[DATA_BYTES-1-k] = 1'b1;
      return m;
   endfunction

   function automatic logic [W-1:0] mask_data(input logic [W-1:0] d, input logic [DATA_BYTES-1:0] be);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < DATA_BYTES; k++)
         r[k*8 +: 8] = be[k] ? d[k*8 +: 8] : 8'h00;
      return r;
   endfunction

   // Residual lives in the LS R bytes of the previously accepted word.
   function automatic logic [W-1:0] realign(input logic [W-1:0] hi, input logic [W-1:0] lo);
      logic [2*W-1:0] cat;
      cat = {hi, lo};
      return cat[W+R*8-1 -: W];
   endfunction

   assign oReady = !iReset && (state != FLUSH) && (!oPayload_valid || iPayload_ready);

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      first_nxt = first_pend;
      flush_nxt = flush_n;
      shadow_wr = 1'b0;
      resid_ld  = 1'b0;
      commit    = 1'b0;
      runt_nxt  = 1'b0;
      load_out  = 1'b0;
      emit_sop  = 1'b0;
      emit_eop  = 1'b0;
      emit_data = '0;
      emit_be   = '0;
      accept    = iValid && oReady;
      v         = count_bytes(iByte_enable);
      total     = (CW+1)'(R) + {1'b0, v};
      capture   = accept && (iSop || state == HEADER);
      idx       = iSop ? '0 : wcnt;
      hdr_full  = shadow;

      if (capture) begin
         hdr_full[(HW-1-int'(idx))*W +: W] = iPacket;
         shadow_wr = 1'b1;
         if (int'(idx) != HW-1) begin
            if (iEop) begin
               runt_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = HEADER;
               wcnt_nxt  = idx + WCW'(1);
            end
         end else if (iEop && v < CW'(OFFE)) begin
            runt_nxt  = 1'b1;
            state_nxt = IDLE;
         end else begin
            commit   = 1'b1;
            resid_ld = 1'b1;
            if (!iEop) begin
               state_nxt = PAYLOAD;
               first_nxt = 1'b1;
            end else begin
               state_nxt = IDLE;
               if (v > CW'(OFFE)) begin
                  load_out  = 1'b1;
                  emit_sop  = 1'b1;
                  emit_eop  = 1'b1;
                  emit_be   = top_mask(v - CW'(OFFE));
                  emit_data = mask_data(realign(iPacket, '0), emit_be);
               end
            end
         end
      end else if (accept && state == PAYLOAD) begin
         resid_ld  = 1'b1;
         load_out  = 1'b1;
         emit_sop  = first_pend;
         first_nxt = 1'b0;
         emit_be   = '1;
         if (iEop) begin
            if (total <= (CW+1)'(DATA_BYTES)) begin
               emit_be   = top_mask(CW'(total));
               emit_eop  = 1'b1;
               state_nxt = IDLE;
            end else begin
               flush_nxt = CW'(total - (CW+1)'(DATA_BYTES));
               state_nxt = FLUSH;
            end
         end
         emit_data = mask_data(realign(resid, iPacket), emit_be);
      end else if (state == FLUSH && (!oPayload_valid || iPayload_ready)) begin
         load_out  = 1'b1;
         emit_eop  = 1'b1;
         emit_be   = top_mask(flush_n);
         emit_data = mask_data(realign(resid, '0), emit_be);
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
         wcnt           <= '0;
         shadow         <= '0;
         resid          <= '0;
         first_pend     <= 1'b0;
         flush_n        <= '0;
         oHeader        <= '0;
         oHeader_valid  <= 1'b0;
         oRunt          <= 1'b0;
         oPayload       <= '0;
         oPayload_valid <= 1'b0;
         oSop           <= 1'b0;
         oEop           <= 1'b0;
         oByte_enable   <= '0;
      end else begin
         wcnt          <= wcnt_nxt;
         first_pend    <= first_nxt;
         flush_n       <= flush_nxt;
         oHeader_valid <= commit;
         oRunt         <= runt_nxt;
         if (shadow_wr) shadow <= hdr_full;
         if (resid_ld)  resid  <= iPacket;
         if (commit)    oHeader <= hdr_full[HW*W-1 -: HDR_BYTES*8];
         if (load_out) begin
            oPayload_valid <= 1'b1;
            oPayload       <= emit_data;
            oByte_enable   <= emit_be;
            oSop           <= emit_sop;
            oEop           <= emit_eop;
         end else if (iPayload_ready) begin
            oPayload_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_payload_realigner.sv
// tb/tb_payload_realigner.sv - directed bench for payload_realigner
// Instance a uses HDR_BYTES=14 (residual path), instance b uses HDR_BYTES=16 (passthrough path).
module tb_payload_realigner;
   localparam logic [111:0] H14 = 112'h000102030405060708090A0B0C0D;
   localparam logic [127:0] H16 = 128'h000102030405060708090A0B0C0D0E0F;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, valid, sop, eop, pready, use_b;
   logic [63:0] pkt;
   logic [7:0]  be;

   logic ready_a, pv_a, osop_a, oeop_a, hv_a, runt_a;
   logic [63:0] pay_a;
   logic [7:0]  obe_a;
   logic [111:0] hdr_a;
   logic ready_b, pv_b, osop_b, oeop_b, hv_b, runt_b;
   logic [63:0] pay_b;
   logic [7:0]  obe_b;
   logic [127:0] hdr_b;

   payload_realigner #(.DATA_BYTES(8), .HDR_BYTES(14)) dut_a (
      .iClk(clk), .iReset(rst), .iValid(valid), .oReady(ready_a), .iPacket(pkt),
      .iSop(sop), .iEop(eop), .iByte_enable(be), .oPayload(pay_a), .oPayload_valid(pv_a),
      .iPayload_ready(pready), .oSop(osop_a), .oEop(oeop_a), .oByte_enable(obe_a),
      .oHeader(hdr_a), .oHeader_valid(hv_a), .oRunt(runt_a));

   payload_realigner #(.DATA_BYTES(8), .HDR_BYTES(16)) dut_b (
      .iClk(clk), .iReset(rst), .iValid(valid), .oReady(ready_b), .iPacket(pkt),
      .iSop(sop), .iEop(eop), .iByte_enable(be), .oPayload(pay_b), .oPayload_valid(pv_b),
      .iPayload_ready(pready), .oSop(osop_b), .oEop(oeop_b), .oByte_enable(obe_b),
      .oHeader(hdr_b), .oHeader_valid(hv_b), .oRunt(runt_b));

   logic [63:0] rec_data [64];
   logic [7:0]  rec_be [64];
   logic        rec_sop [64];
   logic        rec_eop [64];
   int rec_n = 0, hv_n_a = 0, runt_n_a = 0, hv_n_b = 0;

   // Record every completed output transfer of instance a, plus pulse counts.
   always @(negedge clk) begin
      if (pv_a && pready && rec_n < 64) begin
         rec_data[rec_n] = pay_a;
         rec_be[rec_n]   = obe_a;
         rec_sop[rec_n]  = osop_a;
         rec_eop[rec_n]  = oeop_a;
         rec_n++;
      end
      if (hv_a)   hv_n_a++;
      if (runt_a) runt_n_a++;
      if (hv_b)   hv_n_b++;
   end

   int n_cmp = 0, n_bad = 0;
   int base_r, base_hv, base_rt;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mkword(input int start, input int n);
      logic [63:0] w;
      w = '0;
      for (int k = 0; k < 8; k++) w = {w[55:0], (k < n) ? 8'(start + k) : 8'h00};
      return w;
   endfunction

   function automatic logic [7:0] mkbe(input int n);
      logic [7:0] m;
      m = '0;
      for (int k = 0; k < 8; k++) m = {m[6:0], (k < n)};
      return m;
   endfunction

   task automatic send_word(input logic [63:0] d, input logic s, input logic e, input logic [7:0] b);
      int waited;
      bit done, r;
      waited = 0;
      done = 0;
      valid = 1'b1; pkt = d; sop = s; eop = e; be = b;
      while (!done) begin
         @(negedge clk);
         r = use_b ? ready_b : ready_a;
         if (r) done = 1;
         @(posedge clk); #1;
         if (!done) begin
            waited++;
            if (waited > 50) begin
               check("send_timeout_ready", r, 1);
               done = 1;
            end
         end
      end
      valid = 1'b0; sop = 1'b0; eop = 1'b0; pkt = '0; be = '0;
   endtask

   task automatic send_pkt(input int len, input int first_byte);
      for (int i = 0; i < len; i += 8) begin
         int n;
         n = (len - i < 8) ? len - i : 8;
         send_word(mkword(first_byte + i, n), i == 0, i + 8 >= len, mkbe(n));
      end
   endtask

   task automatic snap();
      base_r  = rec_n;
      base_hv = hv_n_a;
      base_rt = runt_n_a;
   endtask

   task automatic check_19(input string tag);
      check({tag, "_words"}, rec_n - base_r, 1);
      check({tag, "_data"}, rec_data[base_r], 64'h0E0F101112000000);
      check({tag, "_be"}, rec_be[base_r], 8'hF8);
      check({tag, "_sop_eop"}, {rec_sop[base_r], rec_eop[base_r]}, 2'b11);
      check({tag, "_header"}, hdr_a, H14);
      check({tag, "_hv_pulses"}, hv_n_a - base_hv, 1);
   endtask

   task automatic check_31(input string tag);
      logic [63:0] ed [3];
      logic [7:0]  eb [3];
      logic [1:0]  ef [3];
      ed[0] = 64'h0E0F101112131415; eb[0] = 8'hFF; ef[0] = 2'b10;
      ed[1] = 64'h161718191A1B1C1D; eb[1] = 8'hFF; ef[1] = 2'b00;
      ed[2] = 64'h1E00000000000000; eb[2] = 8'h80; ef[2] = 2'b01;
      check({tag, "_words"}, rec_n - base_r, 3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s_data%0d", tag, i), rec_data[base_r+i], ed[i]);
         check($sformatf("%s_be%0d", tag, i), rec_be[base_r+i], eb[i]);
         check($sformatf("%s_flags%0d", tag, i), {rec_sop[base_r+i], rec_eop[base_r+i]}, ef[i]);
      end
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; sop = 1'b0; eop = 1'b0; pkt = '0; be = '0;
      pready = 1'b1; use_b = 1'b0;

      @(negedge clk);
      check("rst_ready", ready_a, 0);
      check("rst_outputs", {pv_a, osop_a, oeop_a, hv_a, runt_a, obe_a}, 0);
      check("rst_payload", pay_a, 0);
      check("rst_header", hdr_a, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 19-byte packet
      snap();
      send_pkt(19, 0);
      repeat (3) @(posedge clk);
      #1;
      check_19("p19");

      // 10-byte runt with distinct bytes; header must stay as before
      snap();
      send_pkt(10, 8'h40);
      repeat (3) @(posedge clk);
      #1;
      check("runt_pulses", runt_n_a - base_rt, 1);
      check("runt_hv", hv_n_a - base_hv, 0);
      check("runt_words", rec_n - base_r, 0);
      check("runt_header", hdr_a, H14);

      // 31-byte packet with flush cycle
      snap();
      send_pkt(31, 0);
      @(negedge clk);
      check("flush_ready_low", ready_a, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("flush_ready_back", ready_a, 1);
      repeat (2) @(posedge clk);
      #1;
      check_31("p31");
      check("p31_hv_pulses", hv_n_a - base_hv, 1);

      // 31-byte packet with downstream stall
      snap();
      send_word(mkword(0, 8), 1'b1, 1'b0, 8'hFF);
      send_word(mkword(8, 8), 1'b0, 1'b0, 8'hFF);
      send_word(mkword(16, 8), 1'b0, 1'b0, 8'hFF);
      pready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("stall_ready%0d", i), ready_a, 0);
         check($sformatf("stall_hold%0d", i), {pv_a, pay_a}, {1'b1, 64'h0E0F101112131415});
         @(posedge clk); #1;
      end
      pready = 1'b1;
      send_word(mkword(24, 7), 1'b0, 1'b1, 8'hFE);
      repeat (4) @(posedge clk);
      #1;
      check_31("stall");

      // reset in the middle of a packet
      send_word(mkword(0, 8), 1'b1, 1'b0, 8'hFF);
      send_word(mkword(8, 8), 1'b0, 1'b0, 8'hFF);
      rst = 1'b1;
      #2;
      check("midrst_ready", ready_a, 0);
      check("midrst_outputs", {pv_a, osop_a, oeop_a, hv_a, runt_a, obe_a}, 0);
      check("midrst_payload", pay_a, 0);
      check("midrst_header", hdr_a, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      snap();
      send_pkt(19, 0);
      repeat (3) @(posedge clk);
      #1;
      check_19("after_rst");

      // passthrough instance, HDR_BYTES=16
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      use_b = 1'b1;
      base_hv = hv_n_b;
      send_word(mkword(0, 8), 1'b1, 1'b0, 8'hFF);
      send_word(mkword(8, 8), 1'b0, 1'b0, 8'hFF);
      check("b_no_early_payload", pv_b, 0);
      check("b_header", hdr_b, H16);
      send_word(mkword(16, 8), 1'b0, 1'b1, 8'hFF);
      @(negedge clk);
      check("b_latency_valid", pv_b, 1);
      check("b_data", pay_b, 64'h1011121314151617);
      check("b_be", obe_b, 8'hFF);
      check("b_sop_eop", {osop_b, oeop_b}, 2'b11);
      check("b_no_runt", runt_b, 0);
      repeat (2) @(posedge clk);
      #1;
      check("b_hv_pulses", hv_n_b - base_hv, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
